// File: rtl/wbs_wide_entry_port.sv
// Wishbone-classic slave that assembles 32-bit beats into wide
// memory entries and slices buffered entries back out for reads.
module wbs_wide_entry_port #(
    parameter int          WB_WIDTH       = 32,
    parameter int          WIDE_WIDTH     = 66,
    parameter int          MEM_ADDR_WIDTH = 9,
    parameter logic [31:0] BASE_ADDR      = 32'h3002_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
    parameter int          READ_LATENCY   = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      rst_n,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [WB_WIDTH/8-1:0]     wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [WB_WIDTH-1:0]       wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [WB_WIDTH-1:0]       wbs_dat_o,
    output logic                      mem_wen,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDE_WIDTH-1:0]     mem_wdata,
    input  logic [WIDE_WIDTH-1:0]     mem_rdata,
    output logic                      err_o,
    output logic [MEM_ADDR_WIDTH:0]   commit_cnt_o
);

    localparam int BEATS     = (WIDE_WIDTH + 31) / 32;
    localparam int SLOT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANES     = BEATS * 4;
    localparam int MAW       = MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;
    logic [MAW-1:0]        addr_q, addr_d;
    logic [MAW:0]          cnt_q, cnt_d;
    logic [WIDE_WIDTH-1:0] stage_q, stage_d;
    logic [MAW-1:0]        stage_ent_q, stage_ent_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic [WIDE_WIDTH-1:0] rbuf_q, rbuf_d;
    logic [MAW-1:0]        rbuf_ent_q, rbuf_ent_d;
    logic                  rbuf_vld_q, rbuf_vld_d;
    logic [SLOT_BITS-1:0]  beat_q, beat_d;
    logic [2:0]            lat_q, lat_d;

    logic                  hit;
    logic [SLOT_BITS-1:0]  beat;
    logic [MAW-1:0]        entry;
    logic                  beat_ok;
    logic [LANES-1:0]      mask_t;
    logic                  missing;

    assign hit     = wbs_stb_i & wbs_cyc_i
                   & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign beat    = wbs_adr_i[2 +: SLOT_BITS];
    assign entry   = wbs_adr_i[2 + SLOT_BITS +: MAW];
    assign beat_ok = int'(beat) < BEATS;

    // 32-bit slice of an entry; bits above the entry width read as zero
    function automatic logic [31:0] slice(
        input logic [WIDE_WIDTH-1:0] w,
        input logic [SLOT_BITS-1:0]  b
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < WIDE_WIDTH; i++) begin
            if (i / 32 == int'(b)) r[i % 32] = w[i];
        end
        return r;
    endfunction

    // Next-state, write merge / commit and read-buffer control
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        err_d       = err_q;
        dat_d       = dat_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        stage_ent_d = stage_ent_q;
        mask_d      = mask_q;
        rbuf_d      = rbuf_q;
        rbuf_ent_d  = rbuf_ent_q;
        rbuf_vld_d  = rbuf_vld_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        mask_t      = mask_q;
        missing     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit && wbs_we_i) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (!beat_ok) begin
                        err_d = 1'b1;
                    end else begin
                        if (entry != stage_ent_q && mask_q != '0) begin
                            err_d  = 1'b1;
                            mask_t = '0;
                        end
                        stage_ent_d = entry;
                        for (int i = 0; i < WIDE_WIDTH; i++) begin
                            if (i / 32 == int'(beat) && wbs_sel_i[(i % 32) / 8])
                                stage_d[i] = wbs_dat_i[i % 32];
                        end
                        for (int k = 0; k < LANES; k++) begin
                            if (k / 4 == int'(beat) && wbs_sel_i[k % 4])
                                mask_t[k] = 1'b1;
                        end
                        if (int'(beat) == BEATS - 1) begin
                            for (int k = 0; k < LANES; k++) begin
                                if (k / 4 < BEATS - 1 && !mask_t[k])
                                    missing = 1'b1;
                            end
                            if (missing) err_d = 1'b1;
                            wen_d      = 1'b1;
                            addr_d     = entry;
                            mask_d     = '0;
                            rbuf_vld_d = 1'b0;
                            if (cnt_q != '1) cnt_d = cnt_q + (MAW+1)'(1);
                        end else begin
                            mask_d = mask_t;
                        end
                    end
                end else if (hit) begin
                    beat_d = beat;
                    if (rbuf_vld_q && rbuf_ent_q == entry) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        dat_d   = slice(rbuf_q, beat);
                    end else begin
                        state_d    = RD_WAIT;
                        ren_d      = 1'b1;
                        addr_d     = entry;
                        lat_d      = '0;
                        rbuf_ent_d = entry;
                        rbuf_vld_d = 1'b0;
                    end
                end
            end
            RD_WAIT: begin
                if (int'(lat_q) == READ_LATENCY - 1) begin
                    state_d    = ACK;
                    ack_d      = 1'b1;
                    rbuf_d     = mem_rdata;
                    rbuf_vld_d = 1'b1;
                    dat_d      = slice(mem_rdata, beat_q);
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transaction
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            stage_q     <= '0;
            stage_ent_q <= '0;
            mask_q      <= '0;
            rbuf_q      <= '0;
            rbuf_ent_q  <= '0;
            rbuf_vld_q  <= 1'b0;
            beat_q      <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            stage_ent_q <= stage_ent_d;
            mask_q      <= mask_d;
            rbuf_q      <= rbuf_d;
            rbuf_ent_q  <= rbuf_ent_d;
            rbuf_vld_q  <= rbuf_vld_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign mem_wen      = wen_q;
    assign mem_ren      = ren_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = stage_q;
    assign err_o        = err_q;
    assign commit_cnt_o = cnt_q;

endmodule
